mem_bus_arbiter: RTL and testbench

//  Shares one valid/ready memory slave (the on-chip BRAM controller) between two

---
 rtl/mem_bus_arbiter.sv | 108 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master valid/ready arbiter for one memory slave
// Whole-transaction grants with a forced idle gap and a no-response watchdog.
module mem_bus_arbiter #(
  parameter int          ARB_MODE       = 0,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_err,
  output logic        owner
);

  localparam int             CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit             WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0]  WD_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t        state, state_nxt;
  logic          owner_nxt;
  logic [CW-1:0] cnt;
  logic          done;
  logic [31:0]   resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (state == BUSY) begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    done        = 1'b0;
    resp        = ERR_DATA;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          // owner holds the last grant, so round-robin hands a tie to the other master
          if (m0_valid && m1_valid) owner_nxt = (ARB_MODE == 0) ? ~owner : 1'b0;
          else                      owner_nxt = m1_valid;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_valid = 1'b1;
        s_addr  = owner ? m1_addr  : m0_addr;
        s_wdata = owner ? m1_wdata : m0_wdata;
        s_wstrb = owner ? m1_wstrb : m0_wstrb;
        if (s_ready) begin
          done = 1'b1;
          resp = s_rdata;
        end else if (WD_EN && cnt == WD_LAST) begin
          done        = 1'b1;
          timeout_err = 1'b1;
        end
        if (done) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_ready = done & ~owner;
  assign m1_ready = done & owner;
  assign m0_rdata = m0_ready ? resp : 32'h0;
  assign m1_rdata = m1_ready ? resp : 32'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter
// Drives transactions one at a time against a word-memory slave and a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int TO = 8;

  logic clk, reset_n;
  logic m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic s_valid, s_ready, timeout_err, owner;
  logic [31:0] s_addr, s_wdata, s_rdata;

  logic fp_m0_valid, fp_m0_ready, fp_m1_valid, fp_m1_ready;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata, fp_s_rdata;
  logic [3:0]  fp_s_wstrb;
  logic fp_s_valid, fp_s_ready, fp_timeout_err, fp_owner;
  logic [31:0] fp_addr0, fp_addr1;

  assign fp_s_ready = fp_s_valid;
  assign fp_s_rdata = fp_s_addr;

  mem_bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .timeout_err(timeout_err), .owner(owner)
  );

  mem_bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(0), .ERR_DATA(32'hDEAD_BEEF)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(fp_m0_valid), .m0_ready(fp_m0_ready), .m0_addr(fp_addr0), .m0_wdata(32'h0),
    .m0_wstrb(4'h0), .m0_rdata(fp_m0_rdata),
    .m1_valid(fp_m1_valid), .m1_ready(fp_m1_ready), .m1_addr(fp_addr1), .m1_wdata(32'h0),
    .m1_wstrb(4'h0), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_ready(fp_s_ready), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_wstrb(fp_s_wstrb), .s_rdata(fp_s_rdata), .timeout_err(fp_timeout_err), .owner(fp_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];
  int exp_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Serve one granted transaction of master m; entered during the IDLE cycle that sees its request.
  task automatic serve(input int m, input int lat);
    logic [31:0] ea, ed, exp_rd, rd, ord;
    logic [3:0]  ew;
    logic        rdy, ordy;
    int          c;
    bit          fin;
    ea = m ? m1_addr : m0_addr;
    ed = m ? m1_wdata : m0_wdata;
    ew = m ? m1_wstrb : m0_wstrb;
    exp_last = m;
    @(posedge clk); #1;
    check("s_valid_rise", s_valid, 1);
    check("owner", owner, m);
    check("s_addr", s_addr, ea);
    check("s_wdata", s_wdata, ed);
    check("s_wstrb", s_wstrb, ew);
    if ($urandom_range(3) == 0) begin
      if (m) m1_valid = 1'b0; else m0_valid = 1'b0;
    end
    c = 0;
    fin = 0;
    while (!fin) begin
      if (c == lat || (lat < 0 && c == TO - 1)) begin
        if (lat >= 0) begin
          s_ready = 1'b1;
          s_rdata = slv_mem[s_addr[7:2]];
          exp_rd  = ref_mem[ea[7:2]];
        end else begin
          s_rdata = $urandom;
          exp_rd  = 32'hDEAD_BEEF;
        end
        #1;
        rdy  = m ? m1_ready : m0_ready;
        rd   = m ? m1_rdata : m0_rdata;
        ordy = m ? m0_ready : m1_ready;
        ord  = m ? m0_rdata : m1_rdata;
        check("owner_ready", rdy, 1);
        check("owner_rdata", rd, exp_rd);
        check("timeout_err", timeout_err, (lat < 0) ? 1 : 0);
        check("other_ready", ordy, 0);
        check("other_rdata", ord, 0);
        check("s_addr_end", s_addr, ea);
        if (lat >= 0) begin
          slv_mem[s_addr[7:2]] = merge(slv_mem[s_addr[7:2]], s_wdata, s_wstrb);
          ref_mem[ea[7:2]]     = merge(ref_mem[ea[7:2]], ed, ew);
        end
        fin = 1;
      end else begin
        #1;
        check("wait_ready", {m0_ready, m1_ready, timeout_err}, 0);
        check("wait_s_valid", s_valid, 1);
        @(posedge clk); #1;
        c++;
      end
    end
    @(posedge clk); #1;
    check("release_s_valid", s_valid, 0);
    check("release_ready", {m0_ready, m1_ready}, 0);
    s_ready = 1'b0;
    if (m) m1_valid = 1'b0; else m0_valid = 1'b0;
  endtask

  task automatic run_txn(input bit r0, input bit r1, input int lat_a, input int lat_b);
    int first;
    m0_valid = r0;
    m1_valid = r1;
    if (r0 && r1) first = (exp_last == 1) ? 0 : 1;
    else          first = r1 ? 1 : 0;
    serve(first, lat_a);
    @(posedge clk); #1;
    check("idle_s_valid", s_valid, 0);
    if (r0 && r1) begin
      serve(1 - first, lat_b);
      @(posedge clk); #1;
      check("idle_s_valid2", s_valid, 0);
    end
  endtask

  task automatic rand_master(input int m);
    logic [31:0] a, d;
    logic [3:0]  w;
    a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    d = $urandom;
    w = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom);
    if (m) begin m1_addr = a; m1_wdata = d; m1_wstrb = w; end
    else   begin m0_addr = a; m0_wdata = d; m0_wstrb = w; end
  endtask

  function automatic int rand_lat();
    int l;
    l = $urandom_range(0, TO);
    return (l == TO) ? -1 : l;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int sel, p0, p1;
    reset_n = 1'b0;
    m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0;
    m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    fp_m0_valid = 0; fp_m1_valid = 0; fp_addr0 = 32'h100; fp_addr1 = 32'h200;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'h1000_0000 + i;
      slv_mem[i] = 32'h1000_0000 + i;
    end
    exp_last = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_valid", s_valid, 0);
    check("rst_ready", {m0_ready, m1_ready, timeout_err}, 0);
    check("rst_owner", owner, 1);
    check("rst_s_addr", s_addr, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // tie after reset goes to m0, then alternation under repeated ties
    m0_addr = 32'h10; m0_wstrb = 0; m1_addr = 32'h14; m1_wstrb = 0;
    for (int k = 0; k < 3; k++) run_txn(1, 1, 1, 0);

    m0_addr = 32'h40; m0_wstrb = 4'h0;
    ref_mem[16] = 32'h1234_5678; slv_mem[16] = 32'h1234_5678;
    run_txn(1, 0, 2, 0);

    m1_addr = 32'h80; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    run_txn(0, 1, 1, 0);
    m0_addr = 32'h80; m0_wstrb = 4'h0;
    run_txn(1, 0, 0, 0);
    check("readback_cafe", slv_mem[32], 32'hCAFE_F00D);

    run_txn(1, 0, -1, 0);
    run_txn(1, 0, TO - 1, 0);

    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(1, 3);
      rand_master(0);
      rand_master(1);
      run_txn(sel[0], sel[1], rand_lat(), rand_lat());
    end

    // reset in the middle of a transaction
    m0_addr = 32'h44; m0_wstrb = 0; m0_valid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("midrst_s_valid", s_valid, 0);
    check("midrst_ready", {m0_ready, m1_ready, timeout_err}, 0);
    check("midrst_owner", owner, 1);
    check("midrst_s_addr", s_addr, 0);
    s_ready = 1'b0;
    m0_valid = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_last = 1;
    @(posedge clk); #1;
    run_txn(1, 0, 2, 0);

    // fixed priority: both request continuously, m0 must win every grant
    fp_m0_valid = 1; fp_m1_valid = 1;
    p0 = 0; p1 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fp_m0_ready) p0++;
      if (fp_m1_ready) p1++;
      if (fp_s_valid) check("fp_owner", fp_owner, 0);
    end
    check("fp_m0_grants", p0, 10);
    check("fp_m1_grants", p1, 0);
    fp_m0_valid = 0; fp_m1_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
